// File: rtl/rw_stage.sv
// Register-write stage and 16x32 architectural register file with two async read ports.
// Optional RW_BYPASS_EN macro enables write-through forwarding on the read ports.
module rw_stage #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_ir,
  input  logic [31:0]              in_alu_result,
  input  logic [31:0]              in_ld_result,
  input  logic [$clog2(NREGS)-1:0] rd_addr1,
  input  logic [$clog2(NREGS)-1:0] rd_addr2,
  output logic [31:0]              rd_data1,
  output logic [31:0]              rd_data2,
  output logic                     hazard,
  output logic                     halted,
  output logic [CNT_W-1:0]         retired_cnt
);

  localparam int unsigned AW = $clog2(NREGS);

  localparam logic [4:0] OpCmp  = 5'b00101;
  localparam logic [4:0] OpAluHi = 5'b01001;
  localparam logic [4:0] OpLd   = 5'b01110;
  localparam logic [4:0] OpCall = 5'b10011;
  localparam logic [4:0] OpHlt  = 5'b11111;

  logic             stage_valid_q, stage_valid_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      alu_q, alu_d;
  logic [31:0]      ld_q, ld_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      regs_q [NREGS];

  logic [4:0]    op;
  logic          wen;
  logic [AW-1:0] dest;
  logic [31:0]   wdata;
  logic          transfer;
  logic          commit;
  logic          unused_ir;

  assign op        = ir_q[31:27];
  assign unused_ir = ^{ir_q[26], ir_q[21:0]};

  assign in_ready  = ~halted_q;
  assign transfer  = in_valid & in_ready;
  assign commit    = stage_valid_q;

  // Writers: ALU ops 00000..01001 except cmp, plus ld and call.
  always_comb begin
    wen = 1'b0;
    if ((op <= OpAluHi) && (op != OpCmp)) begin
      wen = 1'b1;
    end else if ((op == OpLd) || (op == OpCall)) begin
      wen = 1'b1;
    end
  end

  always_comb begin
    dest  = ir_q[25:22];
    wdata = alu_q;
    if (op == OpCall) begin
      dest  = AW'(NREGS - 1);
      wdata = {{(32 - PC_W){1'b0}}, pc_q + PC_W'(1)};
    end else if (op == OpLd) begin
      wdata = ld_q;
    end
  end

  always_comb begin
    stage_valid_d = transfer;
    pc_d          = pc_q;
    ir_d          = ir_q;
    alu_d         = alu_q;
    ld_d          = ld_q;
    halted_d      = halted_q;
    cnt_d         = cnt_q;
    if (transfer) begin
      pc_d  = in_pc;
      ir_d  = in_ir;
      alu_d = in_alu_result;
      ld_d  = in_ld_result;
    end
    if (commit) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (op == OpHlt) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      pc_q          <= '0;
      ir_q          <= '0;
      alu_q         <= '0;
      ld_q          <= '0;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      alu_q         <= alu_d;
      ld_q          <= ld_d;
      halted_q      <= halted_d;
      cnt_q         <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit && wen) begin
      regs_q[dest] <= wdata;
    end
  end

`ifdef RW_BYPASS_EN
  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    rd_data2 = regs_q[rd_addr2];
    if (stage_valid_q && wen && (dest == rd_addr1)) begin
      rd_data1 = wdata;
    end
    if (stage_valid_q && wen && (dest == rd_addr2)) begin
      rd_data2 = wdata;
    end
  end
  assign hazard = 1'b0;
`else
  assign rd_data1 = regs_q[rd_addr1];
  assign rd_data2 = regs_q[rd_addr2];
  assign hazard   = stage_valid_q & wen & ((dest == rd_addr1) | (dest == rd_addr2));
`endif

  assign halted      = halted_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_rw_stage.sv
// Self-checking bench for rw_stage: table of single retiring instructions plus
// back-to-back, reset-mid-operation and hlt sequences, with an expected-write scoreboard.
module tb_rw_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_pc;
  logic [31:0] in_ir;
  logic [31:0] in_alu_result;
  logic [31:0] in_ld_result;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        hazard;
  logic        halted;
  logic [15:0] retired_cnt;

  rw_stage #(.NREGS(16), .PC_W(10), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_ir        (in_ir),
    .in_alu_result(in_alu_result),
    .in_ld_result (in_ld_result),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .rd_data1     (rd_data1),
    .rd_data2     (rd_data2),
    .hazard       (hazard),
    .halted       (halted),
    .retired_cnt  (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [9:0]  pc;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [3:0]  chk_addr;
    logic [31:0] chk_data;
    logic        wen;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t        vecs [12];
  wr_t         sb [$];
  wr_t         e;
  logic [31:0] exp_regs [16];
  logic [31:0] old;
  int          checks;
  int          failures;
  int          exp_cnt;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rd);
    return {op, 1'b0, rd, 22'h0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_pc         = '0;
    in_ir         = '0;
    in_alu_result = '0;
    in_ld_result  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr1 = 4'(i);
      rd_addr2 = 4'(15 - i);
      #1;
      chk({tag, "_rd1"}, rd_data1, 32'h0);
      chk({tag, "_rd2"}, rd_data2, 32'h0);
    end
    chk({tag, "_hazard"}, {31'h0, hazard}, 32'h0);
    chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
    chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    chk({tag, "_cnt"}, {16'h0, retired_cnt}, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rd_addr1 = '0;
    rd_addr2 = '0;

    vecs[0]  = '{mk(5'b00000, 4'd3),  10'h000, 32'h0000_1234, 32'h0,         4'd3,  32'h0000_1234, 1'b1};
    vecs[1]  = '{mk(5'b10011, 4'd2),  10'h3FF, 32'h5555_5555, 32'h0,         4'd15, 32'h0000_0000, 1'b1};
    vecs[2]  = '{mk(5'b10011, 4'd2),  10'h010, 32'h5555_5555, 32'h0,         4'd15, 32'h0000_0011, 1'b1};
    vecs[3]  = '{mk(5'b01110, 4'd5),  10'h020, 32'h0000_0001, 32'hDEAD_BEEF, 4'd5,  32'hDEAD_BEEF, 1'b1};
    vecs[4]  = '{mk(5'b01111, 4'd5),  10'h021, 32'h0000_AAAA, 32'h0000_BBBB, 4'd5,  32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{mk(5'b00101, 4'd5),  10'h022, 32'h0000_CCCC, 32'h0,         4'd5,  32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{mk(5'b10000, 4'd3),  10'h023, 32'h0000_DDDD, 32'h0,         4'd3,  32'h0000_1234, 1'b0};
    vecs[7]  = '{mk(5'b10100, 4'd15), 10'h024, 32'h0000_EEEE, 32'h0,         4'd15, 32'h0000_0011, 1'b0};
    vecs[8]  = '{mk(5'b01101, 4'd0),  10'h025, 32'h0000_FFFF, 32'h0,         4'd0,  32'h0000_0000, 1'b0};
    vecs[9]  = '{mk(5'b00001, 4'd0),  10'h026, 32'h0000_0055, 32'h0,         4'd0,  32'h0000_0055, 1'b1};
    vecs[10] = '{mk(5'b01001, 4'd7),  10'h027, 32'h0000_0077, 32'h0,         4'd7,  32'h0000_0077, 1'b1};
    vecs[11] = '{mk(5'b01010, 4'd7),  10'h028, 32'h0000_0099, 32'h0,         4'd7,  32'h0000_0077, 1'b0};

    // Reset state
    do_reset();
    check_cleared("reset");

    // Single instructions: staged-cycle hazard/old value, then committed value
    for (int i = 0; i < 12; i++) begin
      old = exp_regs[vecs[i].chk_addr];
      sb.push_back('{vecs[i].chk_addr, vecs[i].chk_data});
      in_valid      = 1'b1;
      in_ir         = vecs[i].ir;
      in_pc         = vecs[i].pc;
      in_alu_result = vecs[i].alu;
      in_ld_result  = vecs[i].ld;
      step();
      idle_inputs();
      rd_addr1 = vecs[i].chk_addr;
      rd_addr2 = ~vecs[i].chk_addr;
      #1;
`ifdef RW_BYPASS_EN
      chk($sformatf("v%0d_hazard", i), {31'h0, hazard}, 32'h0);
      chk($sformatf("v%0d_staged_rd1", i), rd_data1, vecs[i].wen ? vecs[i].chk_data : old);
`else
      chk($sformatf("v%0d_hazard", i), {31'h0, hazard}, {31'h0, vecs[i].wen});
      chk($sformatf("v%0d_staged_rd1", i), rd_data1, old);
`endif
      step();
      e = sb.pop_front();
      rd_addr1 = e.addr;
      rd_addr2 = e.addr;
      #1;
      chk($sformatf("v%0d_rd1", i), rd_data1, e.data);
      chk($sformatf("v%0d_rd2", i), rd_data2, e.data);
      chk($sformatf("v%0d_hazard_after", i), {31'h0, hazard}, 32'h0);
      exp_cnt++;
      chk($sformatf("v%0d_cnt", i), {16'h0, retired_cnt}, 32'(exp_cnt));
      exp_regs[e.addr] = e.data;
    end

    // Back-to-back writes r1..r4, one per cycle
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      in_valid      = 1'b1;
      in_ir         = mk(5'b00000, 4'(i));
      in_alu_result = 32'h100 + 32'(i);
      #1;
      chk($sformatf("b2b_in_ready%0d", i), {31'h0, in_ready}, 32'h1);
      sb.push_back('{4'(i), 32'h100 + 32'(i)});
      step();
    end
    idle_inputs();
    step();
    chk("b2b_cnt", {16'h0, retired_cnt}, 32'd4);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr1 = e.addr;
      rd_addr2 = e.addr;
      #1;
      chk($sformatf("b2b_r%0d", e.addr), rd_data1, e.data);
    end

    // Reset while an instruction is staged: no write, counter cleared
    do_reset();
    in_valid      = 1'b1;
    in_ir         = mk(5'b00000, 4'd6);
    in_alu_result = 32'h66;
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset    = 1'b0;
    rd_addr1 = 4'd6;
    rd_addr2 = 4'd6;
    #1;
    chk("midrst_r6", rd_data1, 32'h0);
    chk("midrst_cnt", {16'h0, retired_cnt}, 32'h0);
    chk("midrst_hazard", {31'h0, hazard}, 32'h0);

    // hlt: follower accepted at hlt commit edge, then input stalls and counter freezes
    in_valid = 1'b1;
    in_ir    = mk(5'b11111, 4'd0);
    step();
    chk("hlt_in_ready_flight", {31'h0, in_ready}, 32'h1);
    in_ir         = mk(5'b00000, 4'd9);
    in_alu_result = 32'h999;
    step();
    chk("hlt_halted", {31'h0, halted}, 32'h1);
    chk("hlt_in_ready", {31'h0, in_ready}, 32'h0);
    in_ir         = mk(5'b00000, 4'd10);
    in_alu_result = 32'hAAA;
    for (int i = 0; i < 5; i++) step();
    chk("hlt_cnt_frozen", {16'h0, retired_cnt}, 32'd2);
    chk("hlt_in_ready_held", {31'h0, in_ready}, 32'h0);
    rd_addr1 = 4'd9;
    rd_addr2 = 4'd10;
    #1;
    chk("hlt_r9", rd_data1, 32'h999);
    chk("hlt_r10", rd_data2, 32'h0);

    do_reset();
    check_cleared("post_hlt_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
